// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin classic Wishbone arbiter sharing one slave among NUM_MASTERS masters,
// with a watchdog that force-errors slave cycles left unanswered for TIMEOUT cycles.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [DATA_WIDTH-1:0]             m_dat_r,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [ADDR_WIDTH-1:0]             s_adr,
    output logic [DATA_WIDTH-1:0]             s_dat_w,
    output logic [SEL_WIDTH-1:0]              s_sel,
    input  logic                              s_ack,
    input  logic                              s_err,
    input  logic [DATA_WIDTH-1:0]             s_dat_r,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              busy
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          g_q, g_d, last_q, last_d, pick;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d, found, in_busy;

    // First requester strictly after the previous owner, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!found && m_cyc[(int'(last_q) + k) % NUM_MASTERS]) begin
                found = 1'b1;
                pick  = IW'((int'(last_q) + k) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    state_d = BUSY;
                    g_d     = pick;
                    grant_d = NUM_MASTERS'(1) << pick;
                end
            end
            BUSY: begin
                if (!m_cyc[g_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = g_q;
                end else if (TIMEOUT != 0 && m_stb[g_q] && !s_ack && !s_err) begin
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = RELEASE;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (!m_cyc[g_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = g_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            g_q     <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_busy = state_q == BUSY;
    assign s_cyc   = in_busy & m_cyc[g_q];
    assign s_stb   = in_busy & m_stb[g_q];
    assign s_we    = in_busy & m_we[g_q];
    assign s_adr   = m_adr[g_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_dat_w = m_dat_w[g_q*DATA_WIDTH +: DATA_WIDTH];
    assign s_sel   = m_sel[g_q*SEL_WIDTH +: SEL_WIDTH];
    assign m_ack   = (in_busy && s_ack) ? (grant_q & m_stb) : '0;
    // The watchdog error is a registered one-cycle pulse issued on entry to RELEASE.
    assign m_err   = (in_busy && s_err) ? (grant_q & m_stb) : (err_q ? grant_q : '0);
    assign m_dat_r = s_dat_r;
    assign grant   = grant_q;
    assign busy    = |grant_q;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed and randomized checks of wb_rr_arbiter against a per-cycle
// reference model whose predictions are queued and compared by a separate monitor.
module tb_wb_rr_arbiter;
    localparam int N = 4;
    localparam int T = 8;

    typedef struct {
        logic [N-1:0] grant, ack, err;
        logic         busy, cyc, stb, we;
        logic [15:0]  adr;
        logic [31:0]  dw, dr;
        logic [3:0]   sel;
    } exp_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic [N-1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*16-1:0] m_adr;
    logic [N*32-1:0] m_dat_w;
    logic [N*4-1:0]  m_sel;
    logic [N-1:0]  m_ack, m_err, grant;
    logic [31:0]   m_dat_r, s_dat_w, s_dat_r = '0;
    logic          s_cyc, s_stb, s_we, s_ack = 1'b0, s_err = 1'b0, busy;
    logic [15:0]   s_adr;
    logic [3:0]    s_sel;
    logic [15:0]   adr [N];
    logic [31:0]   dat [N];
    logic [3:0]    sel [N];

    exp_t q[$];
    int   total = 0, bad = 0;
    bit   track = 0;
    int   own = -1, last = N - 1, ph = 0, wd = 0;
    bit   errp = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_adr[i*16 +: 16]  = adr[i];
            m_dat_w[i*32 +: 32] = dat[i];
            m_sel[i*4 +: 4]    = sel[i];
        end
    end

    wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(16), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
        .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r), .grant(grant), .busy(busy)
    );

    function automatic void chk(string n, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, want, $time);
        end
    endfunction

    // Predict this cycle's outputs, queue them, then advance the model across the clock edge.
    task automatic tick();
        exp_t e;
        logic [N-1:0] oh;
        oh = own >= 0 ? N'(1) << own : '0;
        e.grant = oh;
        e.busy  = own >= 0;
        e.cyc   = ph == 1 && m_cyc[own];
        e.stb   = ph == 1 && m_stb[own];
        e.we    = ph == 1 && m_we[own];
        e.ack   = (ph == 1 && s_ack && m_stb[own]) ? oh : '0;
        e.err   = (ph == 1 && s_err && m_stb[own]) ? oh : (errp ? oh : '0);
        e.adr   = own >= 0 ? adr[own] : '0;
        e.dw    = own >= 0 ? dat[own] : '0;
        e.sel   = own >= 0 ? sel[own] : '0;
        e.dr    = s_dat_r;
        if (track) q.push_back(e);
        @(posedge clk);
        if (rst) begin
            own = -1; last = N - 1; ph = 0; wd = 0; errp = 0;
        end else begin
            errp = 0;
            if (ph == 0) begin
                if (|m_cyc) begin
                    for (int k = 1; k <= N; k++)
                        if (m_cyc[(last + k) % N]) begin
                            own = (last + k) % N;
                            break;
                        end
                    ph = 1;
                    wd = 0;
                end
            end else if (!m_cyc[own]) begin
                last = own; own = -1; ph = 0; wd = 0;
            end else if (ph == 1) begin
                if (m_stb[own] && !s_ack && !s_err) begin
                    wd++;
                    if (wd == T) begin
                        ph = 2; errp = 1; wd = 0;
                    end
                end else begin
                    wd = 0;
                end
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_grant", 32'(grant), 32'(e.grant));
            chk("sb_busy", 32'(busy), 32'(e.busy));
            chk("sb_s_cyc", 32'(s_cyc), 32'(e.cyc));
            chk("sb_s_stb", 32'(s_stb), 32'(e.stb));
            chk("sb_m_ack", 32'(m_ack), 32'(e.ack));
            chk("sb_m_err", 32'(m_err), 32'(e.err));
            chk("sb_dat_r", m_dat_r, e.dr);
            if (e.cyc) begin
                chk("sb_s_we", 32'(s_we), 32'(e.we));
                chk("sb_s_adr", 32'(s_adr), 32'(e.adr));
                chk("sb_s_dat_w", s_dat_w, e.dw);
                chk("sb_s_sel", 32'(s_sel), 32'(e.sel));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            adr[i] = 16'(i * 16'h0100); dat[i] = 32'(i) * 32'h1111_1111; sel[i] = 4'h3;
        end
        adr[1] = 16'h00A4; dat[1] = 32'hDEADBEEF; sel[1] = 4'hF; m_we = 4'b0010;
        tick(); tick();
        track = 1;
        rst = 0;
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_s_cyc", 32'(s_cyc), 0);
        // Simultaneous requests: master 0 wins first, one idle cycle, then master 1.
        m_cyc = 4'b0011; m_stb = 4'b0011;
        tick();
        chk("first_grant", 32'(grant), 32'b0001);
        s_ack = 1; #1;
        chk("ack_m0", 32'(m_ack), 32'b0001);
        m_cyc = 4'b0010;
        tick();
        chk("gap_grant", 32'(grant), 0);
        tick();
        chk("second_grant", 32'(grant), 32'b0010);
        chk("write_adr", 32'(s_adr), 32'h00A4);
        chk("write_dat", s_dat_w, 32'hDEADBEEF);
        chk("write_sel", 32'(s_sel), 32'hF);
        chk("write_we", 32'(s_we), 1);
        chk("ack_m1", 32'(m_ack), 32'b0010);
        s_ack = 0; #1;
        chk("ack_m1_low", 32'(m_ack), 0);
        m_cyc = 4'b0000;
        tick();
        // Masters 1 and 3 alternate with an idle cycle between tenures.
        m_cyc = 4'b1010; m_stb = 4'b1010; s_ack = 1;
        begin
            logic [N-1:0] want;
            want = 4'b1000;
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("rr_grant", 32'(grant), 32'(want));
                chk("rr_ack", 32'(m_ack), 32'(want));
                m_cyc = 4'b1010 & ~want;
                tick();
                chk("rr_gap", 32'(grant), 0);
                m_cyc = 4'b1010;
                want = want == 4'b1000 ? 4'b0010 : 4'b1000;
            end
        end
        // Watchdog: slave never answers master 0.
        m_cyc = 4'b0001; m_stb = 4'b0001; s_ack = 0;
        tick();
        chk("to_grant", 32'(grant), 32'b0001);
        for (int k = 0; k < T; k++) begin
            chk("to_wait_err", 32'(m_err), 0);
            chk("to_wait_cyc", 32'(s_cyc), 1);
            tick();
        end
        chk("to_err", 32'(m_err), 32'b0001);
        chk("to_cyc_low", 32'(s_cyc), 0);
        tick();
        chk("to_err_once", 32'(m_err), 0);
        chk("to_hold", 32'(grant), 32'b0001);
        m_cyc = 4'b0100; m_stb = 4'b0100;
        tick();
        chk("to_idle", 32'(grant), 0);
        tick();
        chk("to_next", 32'(grant), 32'b0100);
        // Ack on the last cycle before timeout wins over the error.
        for (int k = 0; k < T - 1; k++) tick();
        s_ack = 1; #1;
        chk("late_ack", 32'(m_ack), 32'b0100);
        chk("late_no_err", 32'(m_err), 0);
        tick();
        s_ack = 0; #1;
        chk("late_after_err", 32'(m_err), 0);
        chk("late_after_cyc", 32'(s_cyc), 1);
        // Reset mid-transfer.
        rst = 1;
        tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_cyc", 32'(s_cyc), 0);
        rst = 0; m_cyc = 4'b1111; m_stb = 4'b1111;
        tick();
        chk("rst_prio", 32'(grant), 32'b0001);
        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bit stall;
            stall = (c / 300) % 3 == 2;
            for (int i = 0; i < N; i++) begin
                m_cyc[i] = m_cyc[i] ? ($urandom % 5 != 0) : ($urandom % 3 == 0);
                m_stb[i] = m_cyc[i] && ($urandom % 4 != 0);
                m_we[i]  = 1'($urandom);
                adr[i]   = 16'($urandom);
                dat[i]   = $urandom;
                sel[i]   = 4'($urandom);
            end
            s_ack   = !stall && ($urandom % 4 == 0);
            s_err   = !stall && ($urandom % 12 == 0);
            s_dat_r = $urandom;
            rst     = $urandom % 300 == 0;
            tick();
        end
        rst = 0; m_cyc = '0; m_stb = '0; s_ack = 0; s_err = 0;
        tick(); tick();
        @(negedge clk); #1;
        chk("queue_drain", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
